mest_pro_mm_ctrl: RTL and testbench

Main-memory responder for the MESTPro core: the target side of the execute stage's memory request interface (select/cs/we, 16-bit address, 8-bit write data). It accepts one load or store at a time, inserts a programmable number of wait states, and performs the access on an internal word array. It then returns read data with a one-cycle completion pulse and an out-of-range error flag. It sits between the execute stage and the main-memory storage.

---
 rtl/mest_pro_mm_ctrl_if.sv | 26 ++
 rtl/mest_pro_mm_ctrl.sv | 77 +++++++
 tb/tb_mest_pro_mm_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mest_pro_mm_ctrl_if.sv
// mest_pro_mm_ctrl_if: execute-stage to main-memory request/response bundle
interface mest_pro_mm_ctrl_if #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 8
);
    logic                 i_mm_select;
    logic                 i_cs;
    logic                 i_we;
    logic [ADDR_BITS-1:0] i_mm_addr;
    logic [DATA_BITS-1:0] i_mm_dat;
    logic                 o_mm_ready;
    logic                 o_busy;
    logic                 o_mm_done;
    logic [DATA_BITS-1:0] o_mm_rdata;
    logic                 o_mm_err;

    modport master (
        output i_mm_select, i_cs, i_we, i_mm_addr, i_mm_dat,
        input  o_mm_ready, o_busy, o_mm_done, o_mm_rdata, o_mm_err
    );

    modport slave (
        input  i_mm_select, i_cs, i_we, i_mm_addr, i_mm_dat,
        output o_mm_ready, o_busy, o_mm_done, o_mm_rdata, o_mm_err
    );
endinterface

// File: rtl/mest_pro_mm_ctrl.sv
// mest_pro_mm_ctrl: single-outstanding main-memory responder with programmable wait states
module mest_pro_mm_ctrl #(
    parameter int ADDR_BITS   = 16,
    parameter int DATA_BITS   = 8,
    parameter int MEM_AW      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic               clk,
    input  logic               i_reset_n,
    mest_pro_mm_ctrl_if.slave  mm
);
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

    state_t               state_q;
    logic [3:0]           cnt_q;
    logic                 we_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] dat_q;
    logic [DATA_BITS-1:0] rdata_q;
    logic                 done_q;
    logic                 err_q;
    logic [DATA_BITS-1:0] mem_q [2**MEM_AW];

    logic                 accept;
    logic                 in_range;
    logic [MEM_AW-1:0]    idx;

    assign accept   = (state_q == IDLE) && mm.i_mm_select && mm.i_cs;
    assign in_range = addr_q[ADDR_BITS-1:MEM_AW] == '0;
    assign idx      = addr_q[MEM_AW-1:0];

    assign mm.o_mm_ready = state_q == IDLE;
    assign mm.o_busy     = state_q != IDLE;
    assign mm.o_mm_done  = done_q;
    assign mm.o_mm_err   = err_q;
    assign mm.o_mm_rdata = rdata_q;

    // Request FSM: latch on acceptance, count wait states, complete in ACCESS
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            dat_q   <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    we_q    <= mm.i_we;
                    addr_q  <= mm.i_mm_addr;
                    dat_q   <= mm.i_mm_dat;
                    cnt_q   <= 4'(WAIT_STATES);
                    state_q <= (WAIT_STATES == 0) ? ACCESS : WAIT;
                end
                WAIT: if (cnt_q == 4'd1) state_q <= ACCESS;
                      else cnt_q <= cnt_q - 4'd1;
                ACCESS: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                    err_q   <= !in_range;
                    if (!we_q) rdata_q <= in_range ? mem_q[idx] : '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Storage write; the array is deliberately not reset so contents survive reset
    always_ff @(posedge clk) begin
        if (state_q == ACCESS && we_q && in_range) mem_q[idx] <= dat_q;
    end
endmodule

// File: tb/tb_mest_pro_mm_ctrl.sv
// tb_mest_pro_mm_ctrl: directed + randomized checks of two responders (2 and 0 wait states)
module tb_mest_pro_mm_ctrl;
    logic clk = 1'b0;
    logic i_reset_n = 1'b0;
    always #5 clk = ~clk;

    mest_pro_mm_ctrl_if #(.ADDR_BITS(16), .DATA_BITS(8)) ba ();
    mest_pro_mm_ctrl_if #(.ADDR_BITS(16), .DATA_BITS(8)) bb ();

    mest_pro_mm_ctrl #(.ADDR_BITS(16), .DATA_BITS(8), .MEM_AW(10), .WAIT_STATES(2)) dut_a (
        .clk(clk), .i_reset_n(i_reset_n), .mm(ba));
    mest_pro_mm_ctrl #(.ADDR_BITS(16), .DATA_BITS(8), .MEM_AW(10), .WAIT_STATES(0)) dut_b (
        .clk(clk), .i_reset_n(i_reset_n), .mm(bb));

    int checks = 0;
    int passes = 0;
    logic [7:0] mdl [int];
    logic [7:0] last_rd [2];
    logic [9:0] wa0 [$];
    logic [9:0] wa1 [$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive(int w, logic sel, logic cs, logic we, logic [15:0] a, logic [7:0] d);
        if (w == 0) begin
            ba.i_mm_select = sel; ba.i_cs = cs; ba.i_we = we; ba.i_mm_addr = a; ba.i_mm_dat = d;
        end else begin
            bb.i_mm_select = sel; bb.i_cs = cs; bb.i_we = we; bb.i_mm_addr = a; bb.i_mm_dat = d;
        end
    endtask

    task automatic look(int w, output logic rdy, output logic bsy, output logic dn,
                        output logic er, output logic [7:0] rd);
        if (w == 0) begin
            rdy = ba.o_mm_ready; bsy = ba.o_busy; dn = ba.o_mm_done; er = ba.o_mm_err; rd = ba.o_mm_rdata;
        end else begin
            rdy = bb.o_mm_ready; bsy = bb.o_busy; dn = bb.o_mm_done; er = bb.o_mm_err; rd = bb.o_mm_rdata;
        end
    endtask

    task automatic chk_reset_vals(int w, string tag);
        logic rdy, bsy, dn, er;
        logic [7:0] rd;
        look(w, rdy, bsy, dn, er, rd);
        chk({tag, "_ready"}, rdy, 1);
        chk({tag, "_busy"}, bsy, 0);
        chk({tag, "_done"}, dn, 0);
        chk({tag, "_err"}, er, 0);
        chk({tag, "_rdata"}, rd, 0);
    endtask

    // One complete transaction checked against the reference model
    task automatic op(int w, logic we, logic [15:0] a, logic [7:0] d, bit pulse);
        int ws, k, key;
        logic rdy, bsy, dn, er, exp_err, all_busy;
        logic [7:0] rd, exp_rd;
        ws = (w == 0) ? 2 : 0;
        key = w * 1024 + int'(a % 1024);
        exp_err = (a / 1024) != 0;
        exp_rd = we ? last_rd[w] : (exp_err ? 8'h00 : mdl[key]);
        @(negedge clk);
        look(w, rdy, bsy, dn, er, rd);
        chk("ready_before", rdy, 1);
        drive(w, 1, 1, we, a, d);
        @(posedge clk); #1;
        drive(w, 0, 0, ~we, ~a, ~d);
        look(w, rdy, bsy, dn, er, rd);
        all_busy = bsy;
        k = 0;
        dn = 0;
        while (!dn && k < 20) begin
            @(posedge clk); #1;
            k++;
            if (pulse && k == 1) drive(w, 1, 1, 1, 16'h0030, 8'h77);
            if (pulse && k == 2) drive(w, 0, 0, 0, 16'h0000, 8'h00);
            look(w, rdy, bsy, dn, er, rd);
            if (!dn) all_busy &= bsy;
        end
        chk("busy_during", all_busy, 1);
        chk("latency", k, ws + 1);
        chk("ready_at_done", rdy, 1);
        chk("err", er, exp_err);
        chk("rdata", rd, exp_rd);
        @(posedge clk); #1;
        look(w, rdy, bsy, dn, er, rd);
        chk("done_width", dn, 0);
        chk("err_width", er, 0);
        if (we && !exp_err) begin
            mdl[key] = d;
            if (w == 0) wa0.push_back(a[9:0]); else wa1.push_back(a[9:0]);
        end
        if (!we) last_rd[w] = exp_rd;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic rdy, bsy, dn, er;
        logic [7:0] rd;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        drive(0, 0, 0, 0, 16'h0, 8'h0);
        drive(1, 0, 0, 0, 16'h0, 8'h0);
        #12;
        chk_reset_vals(0, "reset_a");
        chk_reset_vals(1, "reset_b");
        @(negedge clk);
        i_reset_n = 1'b1;

        op(0, 1, 16'h0000, 8'h11, 0);
        op(0, 1, 16'h0010, 8'hA5, 0);
        op(0, 0, 16'h0010, 8'h00, 0);
        op(0, 1, 16'h0400, 8'h3C, 0);
        op(0, 0, 16'h0000, 8'h00, 0);
        op(0, 0, 16'h0400, 8'h00, 0);

        // Held request: model expects one completion every WAIT_STATES+2 edges
        @(negedge clk);
        drive(0, 1, 1, 0, 16'h0010, 8'h00);
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
            if (e == 11) drive(0, 0, 0, 0, 16'h0, 8'h0);
            look(0, rdy, bsy, dn, er, rd);
            chk("b2b_done", dn, ((e + 1) % 4) == 0);
            if (dn) chk("b2b_rdata", rd, mdl[16]);
        end
        last_rd[0] = mdl[16];
        @(posedge clk); #1;
        look(0, rdy, bsy, dn, er, rd);
        chk("b2b_idle_after", bsy, 0);

        // Select without chip select never starts a request
        @(negedge clk);
        drive(0, 1, 0, 1, 16'h0010, 8'hEE);
        for (int e = 0; e < 5; e++) begin
            @(posedge clk); #1;
            look(0, rdy, bsy, dn, er, rd);
            chk("nocs_busy", bsy, 0);
            chk("nocs_done", dn, 0);
        end
        drive(0, 0, 0, 0, 16'h0, 8'h0);
        op(0, 0, 16'h0010, 8'h00, 0);

        op(0, 1, 16'h0030, 8'h12, 0);
        op(0, 1, 16'h0031, 8'h44, 1);
        op(0, 0, 16'h0030, 8'h00, 0);
        op(0, 0, 16'h0031, 8'h00, 0);

        op(1, 1, 16'h0005, 8'h55, 0);
        op(1, 0, 16'h0005, 8'h00, 0);

        // Reset while the store is in its wait states must abort it
        op(0, 1, 16'h0020, 8'h5A, 0);
        op(0, 0, 16'h0030, 8'h00, 0);
        @(negedge clk);
        drive(0, 1, 1, 1, 16'h0020, 8'hFF);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 16'h0, 8'h0);
        @(negedge clk);
        i_reset_n = 1'b0;
        #1;
        chk_reset_vals(0, "midrst_a");
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        for (int e = 0; e < 3; e++) begin
            @(posedge clk); #1;
            look(0, rdy, bsy, dn, er, rd);
            chk("midrst_done", dn, 0);
        end
        @(negedge clk);
        i_reset_n = 1'b1;
        op(0, 0, 16'h0020, 8'h00, 0);

        for (int n = 0; n < 40; n++) begin
            int w;
            logic we;
            logic [15:0] a;
            w = int'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) a = 16'h0400 | 16'($urandom_range(0, 16'hFBFF));
            else if (we) a = 16'($urandom_range(0, 1023));
            else if (w == 0) a = {6'd0, wa0[$urandom_range(0, wa0.size() - 1)]};
            else a = {6'd0, wa1[$urandom_range(0, wa1.size() - 1)]};
            op(w, we, a, 8'($urandom), 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
